// File: rtl/time_keeper_ctrl.sv
// time_keeper_ctrl: hh:mm:ss 24-hour time keeper with a RUN/SET_HOUR/SET_MIN
// edit FSM. It takes debounced key pulses and a 1 Hz tick. It drives packed
// BCD digits and an edit-field code to the display scanner. All outputs are
// registered.
module time_keeper_ctrl #(
    parameter int HOUR_MOD = 24,
    parameter int MIN_MOD  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        mode_pulse,
    input  logic        inc_pulse,
    output logic [23:0] bcd_time,
    output logic [1:0]  edit_field,
    output logic        sec_strobe
);

    // Enum encoding equals the edit_field code, so the FSM and the output agree by construction.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    localparam logic [4:0] HOUR_LAST = 5'(HOUR_MOD - 1);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MOD - 1);

    state_t     state;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;

    // Binary 0..63 to two BCD digits. Only 0..59 ever reaches this function.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 6'd10);
        ones = 4'(v % 6'd10);
        return {tens, ones};
    endfunction

    // Mode FSM and time counters. mode_pulse outranks inc_pulse and tick_1hz,
    // and ticks only advance time in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            edit_field <= 2'b00;
            hour       <= '0;
            min        <= '0;
            sec        <= '0;
            sec_strobe <= 1'b0;
        end else begin
            sec_strobe <= 1'b0;
            if (mode_pulse) begin
                case (state)
                    RUN: begin
                        state      <= SET_HOUR;
                        edit_field <= SET_HOUR;
                    end
                    SET_HOUR: begin
                        state      <= SET_MIN;
                        edit_field <= SET_MIN;
                    end
                    default: begin
                        // Leaving SET_MIN restarts the seconds from :00.
                        state      <= RUN;
                        edit_field <= RUN;
                        sec        <= '0;
                    end
                endcase
            end else begin
                case (state)
                    RUN: begin
                        if (tick_1hz) begin
                            sec_strobe <= 1'b1;
                            if (sec >= MIN_LAST) begin
                                sec <= '0;
                                if (min >= MIN_LAST) begin
                                    min  <= '0;
                                    hour <= (hour >= HOUR_LAST) ? 5'd0 : hour + 5'd1;
                                end else begin
                                    min <= min + 6'd1;
                                end
                            end else begin
                                sec <= sec + 6'd1;
                            end
                        end
                    end
                    SET_HOUR: begin
                        if (inc_pulse)
                            hour <= (hour >= HOUR_LAST) ? 5'd0 : hour + 5'd1;
                    end
                    SET_MIN: begin
                        if (inc_pulse)
                            min <= (min >= MIN_LAST) ? 6'd0 : min + 6'd1;
                    end
                    default: begin
                        state      <= RUN;
                        edit_field <= RUN;
                    end
                endcase
            end
        end
    end

    // Registered BCD view of the counters. It lags a counter change by one cycle.
    always_ff @(posedge clk) begin
        if (rst)
            bcd_time <= 24'h000000;
        else
            bcd_time <= {to_bcd({1'b0, hour}), to_bcd(min), to_bcd(sec)};
    end

endmodule

// File: doc/time_keeper_ctrl.md
Name: time_keeper_ctrl

Overview:
- Mode/time-keeping core between the key debouncers and the display scanner in DigitalClock.
- Consumes single-cycle debounced press pulses (mode, inc) and the 1 Hz tick from the clock divider.
- Runs an hh:mm:ss 24-hour counter and a small set-mode FSM.
- Emits packed BCD digits and an edit-field indicator for the display scanner.

Parameters:
- HOUR_MOD, 24, hour wrap modulus (hours count 0..HOUR_MOD-1)
- MIN_MOD, 60, minute and second wrap modulus

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle pulse, once per second
- mode_pulse  in  1  one-cycle debounced press of key_mode
- inc_pulse  in  1  one-cycle debounced press of key_inc
- bcd_time  out  24  {h_tens,h_ones,m_tens,m_ones,s_tens,s_ones}, 4 bits each, MSB first
- edit_field  out  2  00=RUN, 01=SET_HOUR, 10=SET_MIN (11 unused)
- sec_strobe  out  1  one-cycle pulse when the seconds value changes

Behaviour:
- Clock and reset:
  - Single clock domain. All state updates on posedge clk.
  - rst=1 on a clock edge takes priority over every other input.
  - Reset values: hour=0, min=0, sec=0, state=RUN, bcd_time=24'h000000, edit_field=2'b00, sec_strobe=0.
  - Reset asserted mid-edit returns to RUN with time 00:00:00.
- Internal counters:
  - hour is 5 bits, min and sec are 6 bits each, all binary.
  - bcd_time is a registered binary-to-BCD conversion of these counters.
  - bcd_time updates on the cycle after a counter changes (1-cycle latency).
- FSM states: RUN, SET_HOUR, SET_MIN.
  - mode_pulse steps RUN -> SET_HOUR -> SET_MIN -> RUN.
  - State and edit_field change on the edge that samples mode_pulse.
- RUN:
  - On tick_1hz, sec increments.
  - sec 59 -> 0 carries to min; min 59 -> 0 carries to hour; hour 23 -> 0 wraps.
  - 23:59:59 + tick gives 00:00:00.
  - sec_strobe pulses for exactly 1 cycle, aligned with the cycle sec changes.
  - inc_pulse is ignored in RUN.
- SET_HOUR:
  - inc_pulse increments hour mod HOUR_MOD (23 -> 0), with no carry into other fields.
  - tick_1hz is ignored: time is frozen and sec_strobe stays 0.
- SET_MIN:
  - inc_pulse increments min mod MIN_MOD (59 -> 0). Hour is unaffected.
  - tick_1hz is ignored.
- SET_MIN -> RUN transition: sec is cleared to 0 on that same edge, so counting restarts from :00.
- Simultaneous events:
  - mode_pulse together with inc_pulse: mode wins. The state advances and that inc is discarded (not applied to the old or new field).
  - mode_pulse together with tick_1hz in RUN: the tick is discarded and the state moves to SET_HOUR.
  - inc_pulse together with tick_1hz in a SET state: inc is applied, tick ignored.
  - mode_pulse together with tick_1hz in SET_MIN: the state moves to RUN, sec=0, and the tick is discarded.
- Pulse handling:
  - Pulses are edge-free single-cycle inputs; each asserted cycle counts as one event.
  - A pulse held high for N cycles produces N events. Upstream debouncers guarantee 1-cycle pulses.
- Arithmetic: no counter may ever hold an out-of-range value; a compare-and-clear precedes every increment.
- Combinational paths: none from inputs to outputs. All outputs are registered.

Test Plan:
- Release rst after 10 cycles with no pulses: bcd_time=24'h000000, edit_field=00. Then 3 tick_1hz pulses give bcd_time=24'h000003, with exactly 3 sec_strobe pulses.
- 1 mode_pulse, then 1 inc_pulse: edit_field=01 and bcd_time=24'h010000 one cycle after the inc. Then 25 tick_1hz pulses leave bcd_time unchanged.
- In SET_HOUR, issue 24 inc_pulse from hour 0: hour wraps to 00 (bcd h=0x00). Preload 23 and apply 1 inc: 00, with min/sec untouched.
- Set time to 23:59:59 via SET_HOUR/SET_MIN plus ticks, return to RUN, apply 1 tick: bcd_time=24'h000000 with a single sec_strobe. Also check that the SET_MIN -> RUN exit zeroes seconds (12:34:xx becomes 12:34:00).
- Drive mode_pulse and inc_pulse in the same cycle from RUN: state=SET_HOUR and hour unchanged. Repeat from SET_HOUR: state=SET_MIN and neither hour nor min changes.
- Assert rst for 1 cycle while in SET_MIN at 07:42:00: next cycle bcd_time=24'h000000, edit_field=00, and subsequent ticks count normally.
